// File: rtl/tl_ul_inflight_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tl_ul_inflight_buffer
// Description : Registered TL-UL A/D channel buffer with an in-flight limit
//               and a sticky spurious-D-response flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_ul_inflight_buffer #(
    parameter int A_DEPTH      = 4,
    parameter int D_DEPTH      = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_in_valid,
    output logic        a_in_ready,
    input  logic [82:0] a_in_bits,
    output logic        a_out_valid,
    input  logic        a_out_ready,
    output logic [82:0] a_out_bits,
    input  logic        d_in_valid,
    output logic        d_in_ready,
    input  logic [47:0] d_in_bits,
    output logic        d_out_valid,
    input  logic        d_out_ready,
    output logic [47:0] d_out_bits,
    output logic [4:0]  inflight,
    output logic        err_spur_d
);

    localparam int          c_A_W   = 83;
    localparam int          c_D_W   = 48;
    localparam int          c_A_PW  = $clog2(A_DEPTH);
    localparam int          c_D_PW  = $clog2(D_DEPTH);
    localparam logic [4:0]  c_MAX   = 5'(MAX_INFLIGHT);

    logic                r_live;

    // ---------------------------------------------------------------- A FIFO
    logic [c_A_W-1:0]    r_a_mem [A_DEPTH];
    logic [c_A_PW-1:0]   r_a_wptr;
    logic [c_A_PW-1:0]   r_a_rptr;
    logic [c_A_PW:0]     r_a_cnt;
    logic                w_a_full;
    logic                w_a_empty;
    logic                w_a_enq;
    logic                w_a_deq;

    // ---------------------------------------------------------------- D FIFO
    logic [c_D_W-1:0]    r_d_mem [D_DEPTH];
    logic [c_D_PW-1:0]   r_d_wptr;
    logic [c_D_PW-1:0]   r_d_rptr;
    logic [c_D_PW:0]     r_d_cnt;
    logic                w_d_full;
    logic                w_d_empty;
    logic                w_d_enq;
    logic                w_d_deq;

    // ------------------------------------------------------- in-flight gate
    logic [4:0]          r_inflight;
    logic                r_err_spur_d;
    logic                w_gate_open;
    logic                w_inc;
    logic                w_dec;
    logic                w_spur;

    // Readys stay low until the first clock edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign w_a_full    = (r_a_cnt == (c_A_PW+1)'(A_DEPTH));
    assign w_a_empty   = (r_a_cnt == '0);
    assign a_in_ready  = r_live & ~w_a_full;
    assign w_gate_open = (r_inflight != c_MAX);
    assign a_out_valid = ~w_a_empty & w_gate_open;
    assign a_out_bits  = r_a_mem[r_a_rptr];
    assign w_a_enq     = a_in_valid & a_in_ready;
    assign w_a_deq     = a_out_valid & a_out_ready;

    always_ff @(posedge clock) begin
        if (w_a_enq) begin
            r_a_mem[r_a_wptr] <= a_in_bits;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_wptr <= '0;
            r_a_rptr <= '0;
            r_a_cnt  <= '0;
        end else begin
            if (w_a_enq) begin
                r_a_wptr <= r_a_wptr + c_A_PW'(1);
            end
            if (w_a_deq) begin
                r_a_rptr <= r_a_rptr + c_A_PW'(1);
            end
            case ({w_a_enq, w_a_deq})
                2'b10:   r_a_cnt <= r_a_cnt + (c_A_PW+1)'(1);
                2'b01:   r_a_cnt <= r_a_cnt - (c_A_PW+1)'(1);
                default: r_a_cnt <= r_a_cnt;
            endcase
        end
    end

    // D side is never back-pressured by the in-flight counter.
    assign w_d_full    = (r_d_cnt == (c_D_PW+1)'(D_DEPTH));
    assign w_d_empty   = (r_d_cnt == '0);
    assign d_in_ready  = r_live & ~w_d_full;
    assign d_out_valid = ~w_d_empty;
    assign d_out_bits  = r_d_mem[r_d_rptr];
    assign w_d_enq     = d_in_valid & d_in_ready;
    assign w_d_deq     = d_out_valid & d_out_ready;

    always_ff @(posedge clock) begin
        if (w_d_enq) begin
            r_d_mem[r_d_wptr] <= d_in_bits;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_d_wptr <= '0;
            r_d_rptr <= '0;
            r_d_cnt  <= '0;
        end else begin
            if (w_d_enq) begin
                r_d_wptr <= r_d_wptr + c_D_PW'(1);
            end
            if (w_d_deq) begin
                r_d_rptr <= r_d_rptr + c_D_PW'(1);
            end
            case ({w_d_enq, w_d_deq})
                2'b10:   r_d_cnt <= r_d_cnt + (c_D_PW+1)'(1);
                2'b01:   r_d_cnt <= r_d_cnt - (c_D_PW+1)'(1);
                default: r_d_cnt <= r_d_cnt;
            endcase
        end
    end

    // A response with nothing outstanding is still forwarded, only flagged.
    assign w_inc  = w_a_deq;
    assign w_dec  = w_d_enq & (r_inflight != 5'd0);
    assign w_spur = w_d_enq & (r_inflight == 5'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight   <= 5'd0;
            r_err_spur_d <= 1'b0;
        end else begin
            if (w_inc && !w_dec) begin
                r_inflight <= r_inflight + 5'd1;
            end else if (!w_inc && w_dec) begin
                r_inflight <= r_inflight - 5'd1;
            end
            if (w_spur) begin
                r_err_spur_d <= 1'b1;
            end
        end
    end

    assign inflight   = r_inflight;
    assign err_spur_d = r_err_spur_d;

endmodule
`default_nettype wire
